uart_rx_fifo: RTL and testbench

Parametrised successor to the 8N1 receiver. It supports a configurable frame: data bits, parity and stop bits. It oversamples rx with majority voting and rejects false starts. Received words, with per-word error flags, are buffered in a first-word-fall-through FIFO so the consumer can drain bursts; it sits between the rx pin and the consumer logic.

---
 rtl/uart_rx_fifo_pkg.sv | 23 ++
 rtl/uart_rx_fifo_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the oversampling UART receiver.
// Holds the parity mode codes, the receiver FSM state encodings and the
// baud divider helper that the transmitter counterpart also uses.
package uart_rx_fifo_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE_WAIT = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_PAR       = 3'd4;
    localparam logic [2:0] ST_STOP      = 3'd5;
    localparam logic [2:0] ST_PUSH      = 3'd6;

    // Clock cycles per oversample tick, truncated.
    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data write request; accepted when not full, or when full and
//                 a pop happens in the same cycle
//   rd_en         pop request; ignored while empty
//   rd_data       head entry, valid whenever empty=0
//   empty, full   occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // address bits are equal.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with configurable frame
// (DATA_BITS data bits, optional parity, STOP_BITS stop bits) feeding a
// first-word-fall-through FIFO of received words with error flags.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   rx          serial line, idle high, asynchronous
//   rd_en       pop the head entry
//   data        head word, LSB = first received bit
//   frame_err   head entry had a 0 stop bit
//   parity_err  head entry had a parity mismatch
//   rx_empty    FIFO empty; data/flags are valid when low
//   rx_full     FIFO full
//   overrun     sticky: a word was dropped on a full FIFO
// Consumer handshake: rx_empty=0 means the head entry is valid; a cycle
// with rd_en=1 and rx_empty=0 consumes it, rd_en while empty is ignored.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_empty,
    output logic                 rx_full,
    output logic                 overrun
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int MID   = OVERSAMPLE / 2;
    localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int WIDTH = DATA_BITS + 2;

    logic                 rx_meta, rx_sync, rx_prev;
    logic [2:0]           state;
    logic [1:0]           arm_cnt;
    logic                 start_edge;
    logic [TW-1:0]        div_cnt;
    logic                 tick;
    logic [SW-1:0]        samp_cnt;
    logic                 vote_a, vote_b, bit_val, samp_pt;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 fe_r, pe_r, par_bad;
    logic                 wr_en, pop, drop, fifo_empty, fifo_full;
    logic [WIDTH-1:0]     wr_data, rd_data;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == ST_IDLE) && rx_prev && !rx_sync;

    // Oversample tick; realigned to the start edge so sample points sit
    // at a fixed offset into every bit.
    assign tick = (div_cnt == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || start_edge) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
        end
    end

    // Three-sample majority vote; the decision is made at tick MID+1.
    assign samp_pt = tick && (samp_cnt == SW'(MID + 1));
    assign bit_val = (vote_a & vote_b) | (vote_a & rx_sync) | (vote_b & rx_sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (tick) begin
            if (samp_cnt == SW'(MID - 1)) vote_a <= rx_sync;
            if (samp_cnt == SW'(MID))     vote_b <= rx_sync;
        end
    end

    // Odd mode wants an odd count of ones over data+parity, even mode an
    // even count.
    assign par_bad = (PARITY == PAR_ODD) ? ~^{shreg, bit_val} : ^{shreg, bit_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE_WAIT;
            arm_cnt  <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            fe_r     <= 1'b0;
            pe_r     <= 1'b0;
        end else begin
            case (state)
                // The synchroniser flops come out of reset at 1, so the line
                // must read high for three consecutive cycles before arming;
                // this guarantees at least one real sample of rx was high.
                ST_IDLE_WAIT: begin
                    if (!rx_sync) begin
                        arm_cnt <= '0;
                    end else if (arm_cnt == 2'd2) begin
                        arm_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start_edge) state <= ST_START;
                end
                ST_START: begin
                    if (samp_pt) begin
                        if (bit_val) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            fe_r    <= 1'b0;
                            pe_r    <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (samp_pt) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            stop_cnt <= 1'b0;
                            state    <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (samp_pt) begin
                        pe_r  <= par_bad;
                        state <= ST_STOP;
                    end
                end
                // Leave at the last stop-bit sample point rather than the bit
                // end so an immediately following start edge is not missed.
                ST_STOP: begin
                    if (samp_pt) begin
                        if (!bit_val) fe_r <= 1'b1;
                        if (stop_cnt == 1'(STOP_BITS - 1)) state <= ST_PUSH;
                        else stop_cnt <= 1'b1;
                    end
                end
                // A low line here (break or bad stop) must return high before
                // the receiver re-arms, so a held-low line yields one entry.
                ST_PUSH: begin
                    state <= rx_sync ? ST_IDLE : ST_IDLE_WAIT;
                end
                default: state <= ST_IDLE_WAIT;
            endcase
        end
    end

    assign wr_en   = (state == ST_PUSH);
    assign wr_data = {fe_r, pe_r, shreg};
    assign pop     = rd_en && !fifo_empty;
    assign drop    = wr_en && fifo_full && !pop;

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (pop),
        .rd_data(rd_data),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    // A drop takes priority over a clearing pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)       overrun <= 1'b0;
        else if (drop) overrun <= 1'b1;
        else if (pop)  overrun <= 1'b0;
    end

    // Head outputs are forced to 0 while empty so stale memory never shows.
    assign data       = fifo_empty ? '0 : rd_data[DATA_BITS-1:0];
    assign frame_err  = !fifo_empty && rd_data[WIDTH-1];
    assign parity_err = !fifo_empty && rd_data[WIDTH-2];
    assign rx_empty   = fifo_empty;
    assign rx_full    = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: an 8N1 instance (dut0, scoreboarded) and a
// 7-bit even-parity two-stop instance (dut1), both at 2 clocks per tick.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 3125000;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rd0 = 1'b0, rd1 = 1'b0;
    logic [7:0] d0_data;
    logic [6:0] d1_data;
    logic       d0_fe, d0_pe, d0_empty, d0_full, d0_ovr;
    logic       d1_fe, d1_pe, d1_empty, d1_full, d1_ovr;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model for dut0: FIFO contents as {frame_err, parity_err, data}.
    logic [9:0] exp_q[$];
    logic       ovr_m = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd0), .data(d0_data),
        .frame_err(d0_fe), .parity_err(d0_pe), .rx_empty(d0_empty),
        .rx_full(d0_full), .overrun(d0_ovr));

    uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd1), .data(d1_data),
        .frame_err(d1_fe), .parity_err(d1_pe), .rx_empty(d1_empty),
        .rx_full(d1_full), .overrun(d1_ovr));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    // Drives one complete frame, LSB first. par_flip inverts the correct
    // parity bit; stop_bad drives every stop bit low. Line ends idle high.
    task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                              input int parity, input int stops,
                              input bit par_flip, input bit stop_bad);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        if (parity == 1) p = ~p;
        if (par_flip) p = ~p;
        drive_line(which, 1'b0);
        step(BIT);
        for (int i = 0; i < nbits; i++) begin
            drive_line(which, d[i]);
            step(BIT);
        end
        if (parity != 0) begin
            drive_line(which, p);
            step(BIT);
        end
        for (int s = 0; s < stops; s++) begin
            drive_line(which, !stop_bad);
            step(BIT);
        end
        drive_line(which, 1'b1);
    endtask

    task automatic model_push(input logic [9:0] e);
        if (exp_q.size() >= DEPTH) ovr_m = 1'b1;
        else exp_q.push_back(e);
    endtask

    task automatic pop0();
        logic [9:0] dummy;
        rd0 = 1'b1;
        step(1);
        rd0 = 1'b0;
        if (exp_q.size() > 0) begin
            dummy = exp_q.pop_front();
            ovr_m = 1'b0;
        end
    endtask

    task automatic pop1();
        rd1 = 1'b1;
        step(1);
        rd1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(5);
        tests_run++; if (d0_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", d0_empty); end
        tests_run++; if (d0_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", d0_full); end
        tests_run++; if (d0_ovr !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", d0_ovr); end
        tests_run++; if (d0_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", d0_data); end
        tests_run++; if ({d0_fe, d0_pe} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b want 00", {d0_fe, d0_pe}); end
        tests_run++; if ({d1_empty, d1_full, d1_ovr} !== 3'b100) begin tests_failed++; $display("FAIL reset_dut1: got %b want 100", {d1_empty, d1_full, d1_ovr}); end
        rst = 1'b0;
        step(5);
    endtask

    task automatic test_basic();
        send_frame(0, 9'h0F0, 8, 0, 1, 1'b0, 1'b0);
        model_push({2'b00, 8'hF0});
        step(2);
        tests_run++; if (d0_empty !== 1'b0) begin tests_failed++; $display("FAIL basic_not_empty: got %b want 0", d0_empty); end
        tests_run++; if ({d0_fe, d0_pe, d0_data} !== 10'h0F0) begin tests_failed++; $display("FAIL basic_head: got %h want 0f0", {d0_fe, d0_pe, d0_data}); end
        pop0();
        tests_run++; if (d0_empty !== 1'b1) begin tests_failed++; $display("FAIL basic_pop_empty: got %b want 1", d0_empty); end
    endtask

    task automatic test_parity();
        send_frame(1, 9'h025, 7, 2, 2, 1'b1, 1'b0);
        step(2);
        tests_run++; if ({d1_empty, d1_fe, d1_pe, d1_data} !== {3'b001, 7'h25}) begin tests_failed++; $display("FAIL parity_bad: got %b want 0_0_1_%b", {d1_empty, d1_fe, d1_pe, d1_data}, 7'h25); end
        pop1();
        send_frame(1, 9'h025, 7, 2, 2, 1'b0, 1'b0);
        step(2);
        tests_run++; if ({d1_empty, d1_fe, d1_pe, d1_data} !== {3'b000, 7'h25}) begin tests_failed++; $display("FAIL parity_good: got %b want 0_0_0_%b", {d1_empty, d1_fe, d1_pe, d1_data}, 7'h25); end
        pop1();
        step(BIT);
        send_frame(1, 9'h05A, 7, 2, 2, 1'b0, 1'b1);
        step(2);
        tests_run++; if ({d1_empty, d1_fe, d1_pe, d1_data} !== {3'b010, 7'h5A}) begin tests_failed++; $display("FAIL parity_frame: got %b want 0_1_0_%b", {d1_empty, d1_fe, d1_pe, d1_data}, 7'h5A); end
        pop1();
        tests_run++; if (d1_empty !== 1'b1) begin tests_failed++; $display("FAIL parity_drained: got %b want 1", d1_empty); end
    endtask

    task automatic test_frame_err();
        step(BIT);
        send_frame(0, 9'h055, 8, 0, 1, 1'b0, 1'b1);
        model_push({2'b10, 8'h55});
        step(2);
        tests_run++; if ({d0_fe, d0_pe, d0_data} !== exp_q[0]) begin tests_failed++; $display("FAIL frame_err_head: got %h want %h", {d0_fe, d0_pe, d0_data}, exp_q[0]); end
        pop0();
    endtask

    task automatic test_break();
        step(2 * BIT);
        rx0 = 1'b0;
        step(20 * BIT);
        model_push({2'b10, 8'h00});
        tests_run++; if ({d0_empty, d0_fe, d0_pe, d0_data} !== {1'b0, exp_q[0]}) begin tests_failed++; $display("FAIL break_entry: got %h want %h", {d0_empty, d0_fe, d0_pe, d0_data}, {1'b0, exp_q[0]}); end
        pop0();
        step(3 * BIT);
        tests_run++; if (d0_empty !== 1'b1) begin tests_failed++; $display("FAIL break_single: got %b want 1", d0_empty); end
        rx0 = 1'b1;
        step(2 * BIT);
        send_frame(0, 9'h03C, 8, 0, 1, 1'b0, 1'b0);
        model_push({2'b00, 8'h3C});
        step(2);
        tests_run++; if ({d0_empty, d0_fe, d0_pe, d0_data} !== {1'b0, exp_q[0]}) begin tests_failed++; $display("FAIL break_recover: got %h want %h", {d0_empty, d0_fe, d0_pe, d0_data}, {1'b0, exp_q[0]}); end
        pop0();
    endtask

    // Five back-to-back frames into a four-deep FIFO.
    task automatic test_overrun();
        step(BIT);
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 9'(v), 8, 0, 1, 1'b0, 1'b0);
            model_push({2'b00, 8'(v)});
        end
        step(2);
        tests_run++; if (d0_full !== 1'b1) begin tests_failed++; $display("FAIL overrun_full: got %b want 1", d0_full); end
        tests_run++; if (d0_ovr !== ovr_m) begin tests_failed++; $display("FAIL overrun_set: got %b want %b", d0_ovr, ovr_m); end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if ({d0_fe, d0_pe, d0_data} !== exp_q[0]) begin tests_failed++; $display("FAIL overrun_entry%0d: got %h want %h", k, {d0_fe, d0_pe, d0_data}, exp_q[0]); end
            pop0();
            if (k == 0) begin
                tests_run++; if (d0_ovr !== 1'b0) begin tests_failed++; $display("FAIL overrun_clear: got %b want 0", d0_ovr); end
            end
        end
        tests_run++; if (d0_empty !== 1'b1) begin tests_failed++; $display("FAIL overrun_drained: got %b want 1", d0_empty); end
    endtask

    task automatic test_glitch();
        step(BIT);
        rx0 = 1'b0;
        step(3 * DIV);
        rx0 = 1'b1;
        step(2 * BIT);
        tests_run++; if (d0_empty !== 1'b1) begin tests_failed++; $display("FAIL glitch_no_entry: got %b want 1", d0_empty); end
    endtask

    // Abort 0xA5 after four data bits (1,0,1,0) with a reset pulse.
    task automatic test_reset_mid();
        logic [7:0] a5;
        a5 = 8'hA5;
        rx0 = 1'b0;
        step(BIT);
        for (int i = 0; i < 4; i++) begin
            rx0 = a5[i];
            step(BIT);
        end
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        exp_q.delete();
        ovr_m = 1'b0;
        step(BIT);
        rx0 = 1'b1;
        step(2 * BIT);
        tests_run++; if ({d0_empty, d0_ovr} !== 2'b10) begin tests_failed++; $display("FAIL reset_mid_discard: got %b want 10", {d0_empty, d0_ovr}); end
        send_frame(0, 9'h03C, 8, 0, 1, 1'b0, 1'b0);
        model_push({2'b00, 8'h3C});
        step(2);
        tests_run++; if ({d0_empty, d0_fe, d0_pe, d0_data} !== {1'b0, exp_q[0]}) begin tests_failed++; $display("FAIL reset_mid_next: got %h want %h", {d0_empty, d0_fe, d0_pe, d0_data}, {1'b0, exp_q[0]}); end
        pop0();
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit         bad;
        int         npop;
        step(BIT);
        for (int it = 0; it < 24; it++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 5) == 0);
            send_frame(0, {1'b0, d}, 8, 0, 1, 1'b0, bad);
            model_push({bad, 1'b0, d});
            step(BIT);
            tests_run++; if (d0_full !== (exp_q.size() == DEPTH)) begin tests_failed++; $display("FAIL rand_full%0d: got %b want %b", it, d0_full, exp_q.size() == DEPTH); end
            tests_run++; if (d0_ovr !== ovr_m) begin tests_failed++; $display("FAIL rand_overrun%0d: got %b want %b", it, d0_ovr, ovr_m); end
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                if (exp_q.size() > 0) begin
                    tests_run++; if ({d0_empty, d0_fe, d0_pe, d0_data} !== {1'b0, exp_q[0]}) begin tests_failed++; $display("FAIL rand_head%0d: got %h want %h", it, {d0_empty, d0_fe, d0_pe, d0_data}, {1'b0, exp_q[0]}); end
                end else begin
                    tests_run++; if (d0_empty !== 1'b1) begin tests_failed++; $display("FAIL rand_empty%0d: got %b want 1", it, d0_empty); end
                end
                pop0();
            end
        end
        while (exp_q.size() > 0) begin
            tests_run++; if ({d0_empty, d0_fe, d0_pe, d0_data} !== {1'b0, exp_q[0]}) begin tests_failed++; $display("FAIL rand_drain: got %h want %h", {d0_empty, d0_fe, d0_pe, d0_data}, {1'b0, exp_q[0]}); end
            pop0();
        end
        tests_run++; if ({d0_empty, d0_ovr} !== 2'b10) begin tests_failed++; $display("FAIL rand_final: got %b want 10", {d0_empty, d0_ovr}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_break();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
